// File: rtl/id_stage.sv
// rtl/id_stage.sv - RV32I decode stage with busy scoreboard, writeback forwarding and a 1-deep output register.
`timescale 1ns/1ps
module id_stage (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_instr,
  output logic        rf_read_enable,
  output logic [4:0]  rs1_addr,
  output logic [4:0]  rs2_addr,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_rs1_val,
  output logic [31:0] out_rs2_val,
  output logic [31:0] out_imm,
  output logic [4:0]  out_rd,
  output logic [6:0]  out_opcode,
  output logic [2:0]  out_funct3,
  output logic        out_funct7b5,
  output logic        out_writes_rd,
  output logic        out_illegal
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  logic [31:0] busy;
  logic [31:0] busy_nxt;
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic        illegal;
  logic        writes_any;
  logic        writes_rd;
  logic        uses_rs1;
  logic        uses_rs2;
  logic [31:0] imm;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic        fwd1;
  logic        fwd2;
  logic        hazard;
  logic        accept;

  assign opcode         = in_instr[6:0];
  assign rd             = in_instr[11:7];
  assign rs1_addr       = in_instr[19:15];
  assign rs2_addr       = in_instr[24:20];
  assign rf_read_enable = in_valid;

  always_comb begin
    illegal    = 1'b0;
    writes_any = 1'b0;
    uses_rs1   = 1'b0;
    uses_rs2   = 1'b0;
    imm        = 32'd0;
    case (opcode)
      OP_LUI, OP_AUIPC: begin
        writes_any = 1'b1;
        imm        = {in_instr[31:12], 12'd0};
      end
      OP_JAL: begin
        writes_any = 1'b1;
        imm = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
      end
      OP_JALR, OP_LOAD, OP_IMM: begin
        writes_any = 1'b1;
        uses_rs1   = 1'b1;
        imm        = {{20{in_instr[31]}}, in_instr[31:20]};
      end
      OP_BRANCH: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
        imm = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
      end
      OP_STORE: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
        imm      = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      end
      OP_OP: begin
        writes_any = 1'b1;
        uses_rs1   = 1'b1;
        uses_rs2   = 1'b1;
      end
      OP_FENCE: ;
      OP_SYSTEM: imm = {{20{in_instr[31]}}, in_instr[31:20]};
      default: illegal = 1'b1;
    endcase
  end

  assign writes_rd = writes_any && (rd != 5'd0);

  // Writeback data bypasses the register bank so a same-cycle writeback clears the hazard.
  assign fwd1    = wb_valid && (wb_rd == rs1_addr);
  assign fwd2    = wb_valid && (wb_rd == rs2_addr);
  assign rs1_val = (rs1_addr == 5'd0) ? 32'd0 : (fwd1 ? wb_data : rs1_data);
  assign rs2_val = (rs2_addr == 5'd0) ? 32'd0 : (fwd2 ? wb_data : rs2_data);

  assign hazard = (uses_rs1 && (rs1_addr != 5'd0) && busy[rs1_addr] && !fwd1) ||
                  (uses_rs2 && (rs2_addr != 5'd0) && busy[rs2_addr] && !fwd2);

  assign in_ready = (!out_valid || out_ready) && !hazard && !flush && !reset;
  assign accept   = in_valid && in_ready;

  // Clear first, then set, so a same-cycle set and clear of one register leaves it busy.
  always_comb begin
    busy_nxt = busy;
    if (wb_valid && (wb_rd != 5'd0)) busy_nxt[wb_rd] = 1'b0;
    if (accept && writes_rd) busy_nxt[rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy          <= 32'd0;
      out_valid     <= 1'b0;
      out_pc        <= 32'd0;
      out_rs1_val   <= 32'd0;
      out_rs2_val   <= 32'd0;
      out_imm       <= 32'd0;
      out_rd        <= 5'd0;
      out_opcode    <= 7'd0;
      out_funct3    <= 3'd0;
      out_funct7b5  <= 1'b0;
      out_writes_rd <= 1'b0;
      out_illegal   <= 1'b0;
    end else if (flush) begin
      busy      <= 32'd0;
      out_valid <= 1'b0;
    end else begin
      busy <= busy_nxt;
      if (accept) begin
        out_valid     <= 1'b1;
        out_pc        <= in_pc;
        out_rs1_val   <= rs1_val;
        out_rs2_val   <= rs2_val;
        out_imm       <= imm;
        out_rd        <= rd;
        out_opcode    <= opcode;
        out_funct3    <= in_instr[14:12];
        out_funct7b5  <= in_instr[30];
        out_writes_rd <= writes_rd;
        out_illegal   <= illegal;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// tb/tb_id_stage.sv - directed table-driven bench for id_stage plus hazard, stall, flush and reset sequences.
`timescale 1ns/1ps
module tb_id_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_instr;
  logic        rf_read_enable;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_rs1_val;
  logic [31:0] out_rs2_val;
  logic [31:0] out_imm;
  logic [4:0]  out_rd;
  logic [6:0]  out_opcode;
  logic [2:0]  out_funct3;
  logic        out_funct7b5;
  logic        out_writes_rd;
  logic        out_illegal;

  int n_chk  = 0;
  int n_fail = 0;

  id_stage dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
    .rf_read_enable(rf_read_enable), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val), .out_imm(out_imm),
    .out_rd(out_rd), .out_opcode(out_opcode), .out_funct3(out_funct3),
    .out_funct7b5(out_funct7b5), .out_writes_rd(out_writes_rd), .out_illegal(out_illegal)
  );

  always #5 clock = ~clock;

  // Register bank model: every nonzero register holds a pattern tagged with its index.
  function automatic logic [31:0] bank(input logic [4:0] a);
    return 32'hA5A5_0000 | {27'd0, a};
  endfunction
  assign rs1_data = bank(rs1_addr);
  assign rs2_data = bank(rs2_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic flush_pulse();
    in_valid = 1'b0;
    flush    = 1'b1;
    tick();
    flush    = 1'b0;
  endtask

  typedef struct {
    logic [31:0] instr;
    logic [31:0] imm;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic        f7b5;
    logic        wr;
    logic        ill;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{32'h0070_0293, 32'h0000_0007, 7'b0010011, 5'd5,  3'd0, 1'b0, 1'b1, 1'b0}; // addi x5,x0,7
    vecs[1] = '{32'hFE20_AE23, 32'hFFFF_FFFC, 7'b0100011, 5'd28, 3'd2, 1'b1, 1'b0, 1'b0}; // sw x2,-4(x1)
    vecs[2] = '{32'hFE00_0CE3, 32'hFFFF_FFF8, 7'b1100011, 5'd25, 3'd0, 1'b1, 1'b0, 1'b0}; // beq x0,x0,-8
    vecs[3] = '{32'h1234_50B7, 32'h1234_5000, 7'b0110111, 5'd1,  3'd5, 1'b0, 1'b1, 1'b0}; // lui x1,0x12345
    vecs[4] = '{32'hFFFF_FFFF, 32'h0000_0000, 7'b1111111, 5'd31, 3'd7, 1'b1, 1'b0, 1'b1}; // illegal
    vecs[5] = '{32'h0080_00EF, 32'h0000_0008, 7'b1101111, 5'd1,  3'd0, 1'b0, 1'b1, 1'b0}; // jal x1,+8
    vecs[6] = '{32'h0000_0013, 32'h0000_0000, 7'b0010011, 5'd0,  3'd0, 1'b0, 1'b0, 1'b0}; // addi x0,x0,0
    vecs[7] = '{32'h4020_81B3, 32'h0000_0000, 7'b0110011, 5'd3,  3'd0, 1'b1, 1'b1, 1'b0}; // sub x3,x1,x2

    reset = 1'b1; in_valid = 1'b0; in_pc = 32'd0; in_instr = 32'd0;
    wb_valid = 1'b0; wb_rd = 5'd0; wb_data = 32'd0; flush = 1'b0; out_ready = 1'b1;
    #12;
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_busy", dut.busy, 32'd0);
    chk("reset_out_pc", out_pc, 32'd0);
    chk("reset_in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    #1;

    for (int i = 0; i < 8; i++) begin
      flush_pulse();
      in_valid = 1'b1;
      in_instr = vecs[i].instr;
      in_pc    = 32'h0000_1000 + 32'(i * 4);
      #1;
      chk($sformatf("v%0d_in_ready", i), {31'd0, in_ready}, 32'd1);
      chk($sformatf("v%0d_rs1_addr", i), {27'd0, rs1_addr}, {27'd0, vecs[i].instr[19:15]});
      chk($sformatf("v%0d_rf_en", i), {31'd0, rf_read_enable}, 32'd1);
      tick();
      in_valid = 1'b0;
      chk($sformatf("v%0d_valid", i), {31'd0, out_valid}, 32'd1);
      chk($sformatf("v%0d_pc", i), out_pc, 32'h0000_1000 + 32'(i * 4));
      chk($sformatf("v%0d_imm", i), out_imm, vecs[i].imm);
      chk($sformatf("v%0d_op", i), {25'd0, out_opcode}, {25'd0, vecs[i].op});
      chk($sformatf("v%0d_rd", i), {27'd0, out_rd}, {27'd0, vecs[i].rd});
      chk($sformatf("v%0d_f3", i), {29'd0, out_funct3}, {29'd0, vecs[i].f3});
      chk($sformatf("v%0d_f7b5", i), {31'd0, out_funct7b5}, {31'd0, vecs[i].f7b5});
      chk($sformatf("v%0d_wr", i), {31'd0, out_writes_rd}, {31'd0, vecs[i].wr});
      chk($sformatf("v%0d_ill", i), {31'd0, out_illegal}, {31'd0, vecs[i].ill});
      chk($sformatf("v%0d_rs1v", i), out_rs1_val,
          (vecs[i].instr[19:15] == 5'd0) ? 32'd0 : bank(vecs[i].instr[19:15]));
      chk($sformatf("v%0d_rs2v", i), out_rs2_val,
          (vecs[i].instr[24:20] == 5'd0) ? 32'd0 : bank(vecs[i].instr[24:20]));
      chk($sformatf("v%0d_busy", i), dut.busy,
          vecs[i].wr ? (32'd1 << vecs[i].rd) : 32'd0);
    end

    // addi x5 then dependent add x6,x5,x5: stall until writeback forwards x5.
    flush_pulse();
    in_valid = 1'b1; in_instr = 32'h0070_0293; in_pc = 32'h100;
    tick();
    chk("addi_rd", {27'd0, out_rd}, 32'd5);
    chk("addi_imm", out_imm, 32'd7);
    chk("addi_busy5", dut.busy, 32'h20);
    in_instr = 32'h0052_8333; in_pc = 32'h104;
    #1;
    chk("raw_hazard_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    chk("raw_drain_valid", {31'd0, out_valid}, 32'd0);
    wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'h7;
    #1;
    chk("fwd_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    wb_valid = 1'b0; in_valid = 1'b0;
    chk("fwd_rs1", out_rs1_val, 32'h7);
    chk("fwd_rs2", out_rs2_val, 32'h7);
    chk("fwd_pc", out_pc, 32'h104);
    chk("fwd_busy", dut.busy, 32'h40);

    // Backpressure: held output stays stable for 5 cycles, then the waiting instruction enters.
    flush_pulse();
    in_valid = 1'b1; in_instr = 32'h1234_50B7; in_pc = 32'h200;
    tick();
    out_ready = 1'b0; in_instr = 32'h0030_0393; in_pc = 32'h204;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk($sformatf("stall%0d_in_ready", c), {31'd0, in_ready}, 32'd0);
      tick();
      chk($sformatf("stall%0d_valid", c), {31'd0, out_valid}, 32'd1);
      chk($sformatf("stall%0d_pc", c), out_pc, 32'h200);
      chk($sformatf("stall%0d_imm", c), out_imm, 32'h1234_5000);
    end
    out_ready = 1'b1;
    #1;
    chk("unstall_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    chk("unstall_pc", out_pc, 32'h204);
    chk("unstall_imm", out_imm, 32'd3);
    tick();
    chk("drain_valid", {31'd0, out_valid}, 32'd0);

    // Illegal leaves the scoreboard alone; set beats clear; flush wipes everything.
    flush_pulse();
    in_valid = 1'b1; in_instr = 32'h0070_0293; in_pc = 32'h300;
    tick();
    in_instr = 32'hFFFF_FFFF; in_pc = 32'h304;
    tick();
    chk("ill_flag", {31'd0, out_illegal}, 32'd1);
    chk("ill_wr", {31'd0, out_writes_rd}, 32'd0);
    chk("ill_busy", dut.busy, 32'h20);
    in_instr = 32'h0070_0293; in_pc = 32'h308;
    wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'h9;
    tick();
    wb_valid = 1'b0;
    chk("set_wins_busy", dut.busy, 32'h20);
    chk("set_wins_pc", out_pc, 32'h308);
    flush = 1'b1; in_instr = 32'h0030_0393;
    #1;
    chk("flush_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_busy", dut.busy, 32'd0);

    // Asynchronous reset between edges with a held instruction.
    in_valid = 1'b1; in_instr = 32'h0070_0293; in_pc = 32'h400;
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    chk("pre_reset_valid", {31'd0, out_valid}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("async_reset_valid", {31'd0, out_valid}, 32'd0);
    chk("async_reset_busy", dut.busy, 32'd0);
    chk("async_reset_pc", out_pc, 32'd0);
    chk("async_reset_in_ready", {31'd0, in_ready}, 32'd0);
    #1 reset = 1'b0;
    in_valid = 1'b1; in_instr = 32'h0030_0393; in_pc = 32'h500; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("post_reset_valid", {31'd0, out_valid}, 32'd1);
    chk("post_reset_rd", {27'd0, out_rd}, 32'd7);
    chk("post_reset_pc", out_pc, 32'h500);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
